// File: rtl/int_sync_gateway_arbiter.sv
// Interrupt gateway and priority arbiter with a PLIC-style claim/complete handshake.
// Optional: define INT_SYNC_ARB_ROUND_ROBIN_EN for round-robin tie-breaking among equal priorities.
module int_sync_gateway_arbiter #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 3,
  parameter int PRIO_W      = 3,
  parameter int ID_W        = 4
) (
  input  logic                      clock,
  input  logic                      rstnn,
  input  logic [NUM_SRC-1:0]        int_async,
  input  logic [NUM_SRC-1:0]        cfg_edge,
  input  logic [NUM_SRC-1:0]        cfg_enable,
  input  logic [NUM_SRC*PRIO_W-1:0] cfg_prio,
  input  logic [PRIO_W-1:0]         cfg_threshold,
  output logic                      irq_out,
  input  logic                      claim_req,
  output logic                      claim_ack,
  output logic [ID_W-1:0]           claim_id,
  input  logic                      complete_valid,
  input  logic [ID_W-1:0]           complete_id
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PENDING  = 2'd1;
  localparam logic [1:0] ST_INFLIGHT = 2'd2;

  logic [NUM_SRC-1:0]      sync_r [SYNC_STAGES];
  logic [NUM_SRC-1:0]      sync_prev_r;
  logic [NUM_SRC-1:0]      sync_s;
  logic [NUM_SRC-1:0]      rise_s;
  logic [NUM_SRC-1:0][1:0] state_r;
  logic [NUM_SRC-1:0][1:0] state_s;
  logic [NUM_SRC-1:0]      missed_r;
  logic [NUM_SRC-1:0]      missed_s;
  logic [NUM_SRC-1:0]      elig_s;
  logic [NUM_SRC-1:0]      claim_hit_s;
  logic [NUM_SRC-1:0]      cmpl_hit_s;
  logic                    claim_win_s;
  logic                    best_found_s;
  logic [PRIO_W-1:0]       best_prio_s;
  logic [ID_W-1:0]         best_sel_s;
  int                      arb_idx_s;
  logic [PRIO_W-1:0]       arb_prio_s;
  logic                    arb_take_s;
  logic                    best_valid_r;
  logic [ID_W-1:0]         best_id_r;
  logic                    claim_ack_r;
  logic [ID_W-1:0]         claim_id_r;
`ifdef INT_SYNC_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0]         rr_ptr_r;
`endif

  // Synchronizer chain plus one-cycle delayed copy for edge detection.
  always_ff @(posedge clock) begin
    if (!rstnn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= '0;
      sync_prev_r <= '0;
    end else begin
      sync_r[0] <= int_async;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
      sync_prev_r <= sync_s;
    end
  end

  assign sync_s      = sync_r[SYNC_STAGES-1];
  assign rise_s      = sync_s & ~sync_prev_r;
  assign claim_win_s = |claim_hit_s;

  // Per-source eligibility and claim/complete decode; ids outside 1..NUM_SRC never match.
  always_comb begin
    elig_s      = '0;
    claim_hit_s = '0;
    cmpl_hit_s  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig_s[i]      = (state_r[i] == ST_PENDING) && cfg_enable[i] &&
                       (cfg_prio[i*PRIO_W +: PRIO_W] > cfg_threshold);
      claim_hit_s[i] = claim_req && best_valid_r && (best_id_r == ID_W'(i + 1)) &&
                       (state_r[i] == ST_PENDING);
      cmpl_hit_s[i]  = complete_valid && (complete_id == ID_W'(i + 1)) &&
                       (state_r[i] == ST_INFLIGHT);
    end
  end

  // Gateway next state; edge sources remember at most one edge seen while busy.
  always_comb begin
    state_s  = state_r;
    missed_s = missed_r;
    for (int i = 0; i < NUM_SRC; i++) begin
      case (state_r[i])
        ST_IDLE: begin
          if (cfg_edge[i] ? rise_s[i] : sync_s[i]) state_s[i] = ST_PENDING;
          else state_s[i] = ST_IDLE;
        end
        ST_PENDING: begin
          if (claim_hit_s[i]) state_s[i] = ST_INFLIGHT;
          else state_s[i] = ST_PENDING;
          missed_s[i] = missed_r[i] | (cfg_edge[i] & rise_s[i]);
        end
        ST_INFLIGHT: begin
          if (cmpl_hit_s[i]) begin
            if (cfg_edge[i]) state_s[i] = (missed_r[i] | rise_s[i]) ? ST_PENDING : ST_IDLE;
            else state_s[i] = sync_s[i] ? ST_PENDING : ST_IDLE;
            missed_s[i] = 1'b0;
          end else begin
            state_s[i]  = ST_INFLIGHT;
            missed_s[i] = missed_r[i] | (cfg_edge[i] & rise_s[i]);
          end
        end
        default: begin
          state_s[i]  = ST_IDLE;
          missed_s[i] = 1'b0;
        end
      endcase
    end
  end

  // Priority search; strict '>' keeps the first source met in search order on ties.
  always_comb begin
    best_found_s = 1'b0;
    best_prio_s  = '0;
    best_sel_s   = '0;
    arb_idx_s    = 0;
    arb_prio_s   = '0;
    arb_take_s   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
`ifdef INT_SYNC_ARB_ROUND_ROBIN_EN
      arb_idx_s = int'(rr_ptr_r) + k;
      arb_idx_s = (arb_idx_s >= NUM_SRC) ? (arb_idx_s - NUM_SRC) : arb_idx_s;
`else
      arb_idx_s = k;
`endif
      arb_prio_s   = cfg_prio[arb_idx_s*PRIO_W +: PRIO_W];
      arb_take_s   = elig_s[arb_idx_s] && (!best_found_s || (arb_prio_s > best_prio_s));
      best_prio_s  = arb_take_s ? arb_prio_s : best_prio_s;
      best_sel_s   = arb_take_s ? ID_W'(arb_idx_s + 1) : best_sel_s;
      best_found_s = best_found_s | arb_take_s;
    end
  end

  // Gateway state registers.
  always_ff @(posedge clock) begin
    if (!rstnn) begin
      state_r  <= '0;
      missed_r <= '0;
    end else begin
      state_r  <= state_s;
      missed_r <= missed_s;
    end
  end

  // Registered arbiter result and claim response; a stale winner already in flight yields id 0.
  always_ff @(posedge clock) begin
    if (!rstnn) begin
      best_valid_r <= 1'b0;
      best_id_r    <= '0;
      claim_ack_r  <= 1'b0;
      claim_id_r   <= '0;
`ifdef INT_SYNC_ARB_ROUND_ROBIN_EN
      rr_ptr_r     <= '0;
`endif
    end else begin
      best_valid_r <= best_found_s;
      best_id_r    <= best_sel_s;
      claim_ack_r  <= claim_req;
      claim_id_r   <= claim_win_s ? best_id_r : '0;
`ifdef INT_SYNC_ARB_ROUND_ROBIN_EN
      rr_ptr_r     <= claim_win_s ? best_id_r : rr_ptr_r;
`endif
    end
  end

  assign irq_out   = best_valid_r;
  assign claim_ack = claim_ack_r;
  assign claim_id  = claim_id_r;

endmodule
